// File: rtl/multi_port_register_file_if.sv
// Rename/read/commit bus of the multi-port register file.
// The master drives requests; the slave (register file) returns resolved source operands.
interface multi_port_register_file_if #(
  parameter int ROB_WIDTH    = 4,
  parameter int ISSUE_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
);
  logic                              readyIn;
  logic                              clearIn;

  logic [ISSUE_WIDTH-1:0]            rdFlag;
  logic [5*ISSUE_WIDTH-1:0]          rdAddr;
  logic [ROB_WIDTH*ISSUE_WIDTH-1:0]  rdDest;

  logic [5*ISSUE_WIDTH-1:0]          rs1Addr;
  logic [5*ISSUE_WIDTH-1:0]          rs2Addr;
  logic [32*ISSUE_WIDTH-1:0]         rs1Value;
  logic [32*ISSUE_WIDTH-1:0]         rs2Value;
  logic [ROB_WIDTH*ISSUE_WIDTH-1:0]  rs1Rename;
  logic [ROB_WIDTH*ISSUE_WIDTH-1:0]  rs2Rename;
  logic [ISSUE_WIDTH-1:0]            rs1Busy;
  logic [ISSUE_WIDTH-1:0]            rs2Busy;

  logic [COMMIT_WIDTH-1:0]           writeFlag;
  logic [ROB_WIDTH*COMMIT_WIDTH-1:0] robId;
  logic [5*COMMIT_WIDTH-1:0]         writeAddr;
  logic [32*COMMIT_WIDTH-1:0]        writeValue;

  modport master (
    output readyIn, clearIn, rdFlag, rdAddr, rdDest, rs1Addr, rs2Addr,
           writeFlag, robId, writeAddr, writeValue,
    input  rs1Value, rs2Value, rs1Rename, rs2Rename, rs1Busy, rs2Busy
  );

  modport slave (
    input  readyIn, clearIn, rdFlag, rdAddr, rdDest, rs1Addr, rs2Addr,
           writeFlag, robId, writeAddr, writeValue,
    output rs1Value, rs2Value, rs1Rename, rs2Rename, rs1Busy, rs2Busy
  );
endinterface

// File: rtl/multi_port_register_file.sv
// 32x32 architectural register file with busy bits and ROB rename tags.
// Reads bypass same-group renames and same-cycle matching commits.
module multi_port_register_file #(
  parameter int ROB_WIDTH    = 4,
  parameter int ISSUE_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input logic                        clockIn,
  input logic                        resetIn,
  multi_port_register_file_if.slave  rfBus
);

  logic [31:0]          r_regs [32];
  logic [31:0]          r_busy;
  logic [ROB_WIDTH-1:0] r_tag  [32];

  logic [32*ISSUE_WIDTH-1:0]        w_rs1Value;
  logic [32*ISSUE_WIDTH-1:0]        w_rs2Value;
  logic [ROB_WIDTH*ISSUE_WIDTH-1:0] w_rs1Rename;
  logic [ROB_WIDTH*ISSUE_WIDTH-1:0] w_rs2Rename;
  logic [ISSUE_WIDTH-1:0]           w_rs1Busy;
  logic [ISSUE_WIDTH-1:0]           w_rs2Busy;

  // An earlier slot's rename shadows commit forwarding; register 0 overrides everything.
  always_comb begin : readResolve
    logic [4:0]           w_src;
    logic [31:0]          w_val;
    logic                 w_bsy;
    logic [ROB_WIDTH-1:0] w_tag;
    logic                 w_hit;
    w_src       = '0;
    w_val       = '0;
    w_bsy       = 1'b0;
    w_tag       = '0;
    w_hit       = 1'b0;
    w_rs1Value  = '0;
    w_rs2Value  = '0;
    w_rs1Rename = '0;
    w_rs2Rename = '0;
    w_rs1Busy   = '0;
    w_rs2Busy   = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int p = 0; p < 2; p++) begin
        w_src = (p == 0) ? rfBus.rs1Addr[k*5 +: 5] : rfBus.rs2Addr[k*5 +: 5];
        w_val = r_regs[w_src];
        w_bsy = r_busy[w_src];
        w_tag = r_tag[w_src];
        w_hit = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (rfBus.rdFlag[j] && rfBus.rdAddr[j*5 +: 5] == w_src) begin
            w_hit = 1'b1;
            w_bsy = 1'b1;
            w_tag = rfBus.rdDest[j*ROB_WIDTH +: ROB_WIDTH];
          end
        end
        if (!w_hit && r_busy[w_src]) begin
          for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (rfBus.writeFlag[c] && rfBus.writeAddr[c*5 +: 5] == w_src &&
                rfBus.robId[c*ROB_WIDTH +: ROB_WIDTH] == r_tag[w_src]) begin
              w_bsy = 1'b0;
              w_val = rfBus.writeValue[c*32 +: 32];
            end
          end
        end
        if (w_src == 5'd0) begin
          w_val = '0;
          w_bsy = 1'b0;
          w_tag = '0;
        end
        if (p == 0) begin
          w_rs1Value[k*32 +: 32]               = w_val;
          w_rs1Busy[k]                         = w_bsy;
          w_rs1Rename[k*ROB_WIDTH +: ROB_WIDTH] = w_tag;
        end else begin
          w_rs2Value[k*32 +: 32]               = w_val;
          w_rs2Busy[k]                         = w_bsy;
          w_rs2Rename[k*ROB_WIDTH +: ROB_WIDTH] = w_tag;
        end
      end
    end
  end

  assign rfBus.rs1Value  = w_rs1Value;
  assign rfBus.rs2Value  = w_rs2Value;
  assign rfBus.rs1Rename = w_rs1Rename;
  assign rfBus.rs2Rename = w_rs2Rename;
  assign rfBus.rs1Busy   = w_rs1Busy;
  assign rfBus.rs2Busy   = w_rs2Busy;

  // Later loop iterations win, so the highest commit port / issue slot takes priority,
  // and renames are scheduled after busy clears so they override them.
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      for (int r = 0; r < 32; r++) begin
        r_regs[r] <= '0;
        r_tag[r]  <= '0;
      end
      r_busy <= '0;
    end else if (rfBus.readyIn) begin
      for (int c = 0; c < COMMIT_WIDTH; c++) begin
        if (rfBus.writeFlag[c] && rfBus.writeAddr[c*5 +: 5] != 5'd0) begin
          r_regs[rfBus.writeAddr[c*5 +: 5]] <= rfBus.writeValue[c*32 +: 32];
        end
      end
      if (rfBus.clearIn) begin
        r_busy <= '0;
      end else begin
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
          if (rfBus.writeFlag[c] && rfBus.writeAddr[c*5 +: 5] != 5'd0 &&
              rfBus.robId[c*ROB_WIDTH +: ROB_WIDTH] == r_tag[rfBus.writeAddr[c*5 +: 5]]) begin
            r_busy[rfBus.writeAddr[c*5 +: 5]] <= 1'b0;
          end
        end
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          if (rfBus.rdFlag[k] && rfBus.rdAddr[k*5 +: 5] != 5'd0) begin
            r_busy[rfBus.rdAddr[k*5 +: 5]] <= 1'b1;
            r_tag[rfBus.rdAddr[k*5 +: 5]]  <= rfBus.rdDest[k*ROB_WIDTH +: ROB_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: doc/multi_port_register_file.md
MULTI_PORT_REGISTER_FILE -- requirements
Module: MultiPortRegisterFile

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, reorder-buffer tag width.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 2, rename/read slots per cycle (legal 1-4).
REQ-003 SHALL have parameter COMMIT_WIDTH, default 2, commit write ports per cycle (legal 1-4).
REQ-004 SHALL have ports: clockIn  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have ports: resetIn  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports: readyIn  input  1  global enable; clearIn  input  1  pipeline flush.
REQ-007 SHALL have ports, per issue slot k: rdFlag  input  ISSUE_WIDTH  rename request; rdAddr  input  5*ISSUE_WIDTH  destination register; rdDest  input  ROB_WIDTH*ISSUE_WIDTH  ROB tag.
REQ-008 SHALL have ports: rs1Addr, rs2Addr  input  5*ISSUE_WIDTH  source register indices.
REQ-009 SHALL have ports: rs1Value, rs2Value  output  32*ISSUE_WIDTH; rs1Rename, rs2Rename  output  ROB_WIDTH*ISSUE_WIDTH; rs1Busy, rs2Busy  output  ISSUE_WIDTH.
REQ-010 SHALL have ports, per commit port c: writeFlag  input  COMMIT_WIDTH; robId  input  ROB_WIDTH*COMMIT_WIDTH; writeAddr  input  5*COMMIT_WIDTH; writeValue  input  32*COMMIT_WIDTH.
REQ-011 SHALL place slot k (or port c) of every bus at bits [k*W +: W], W being the per-slot width.

Function
REQ-012 SHALL hold 32 x 32-bit registers, a 32-bit busy vector, and 32 ROB_WIDTH-bit rename tags.
REQ-013 SHALL resolve each source read combinationally, in this priority: source 0 -> value 0, busy 0, rename 0.
REQ-014 SHALL, else if the highest-indexed slot j<k has rdFlag[j] and rdAddr[j]==source, return busy 1, rename rdDest[j], value registers[source] (intra-group bypass).
REQ-015 SHALL, else if the source is busy and commit port c has writeFlag[c], writeAddr[c]==source and robId[c]==stored tag, return busy 0, value writeValue[c] (highest matching c wins), rename = stored tag.
REQ-016 SHALL otherwise return stored value, busy and tag.
REQ-017 SHALL change no state while readyIn is low; reads still resolve per REQ-013..016.
REQ-018 SHALL, with readyIn high, write writeValue[c] to writeAddr[c] for every c with writeFlag[c] and writeAddr[c]!=0; the highest c wins on identical addresses.
REQ-019 SHALL clear busy[r] when some commit c targets r with robId[c]==tag[r], unless r is renamed in the same cycle.
REQ-020 SHALL, for every slot with rdFlag and rdAddr!=0, set busy and the tag to rdDest; the highest slot wins on identical rdAddr; a rename overrides a same-cycle busy clear.
REQ-021 SHALL, when clearIn and readyIn are both high, still apply commit value writes (REQ-018), clear all 32 busy bits, and ignore all rename requests; tags are kept.
REQ-022 SHALL never write, mark busy, or rename register 0.
REQ-023 SHALL give a commit whose robId mismatches the stored tag a value write with busy unchanged.

Reset
REQ-024 SHALL, on a rising edge with resetIn low, zero all registers, busy bits and tags regardless of readyIn and clearIn.
REQ-025 SHALL, after reset, read 0 / busy 0 / rename 0 from every source.
REQ-026 SHALL give reset priority over clear, commit and rename in the same cycle.

Verification
REQ-027 Slot 0 renames x5->tag 3, slot 1 reads rs1=x5 same cycle -> rs1Busy[1]=1, rs1Rename[1]=3; next cycle slot 0 read also busy/3.
REQ-028 x5 busy tag 3; commit port 1 writes x5=0xDEAD with robId 3 -> same-cycle read gives 0xDEAD, busy 0; next cycle stored 0xDEAD, busy 0.
REQ-029 Both commit ports write x7 (0x11 on port 0, 0x22 on port 1); slot 0 renames x7->tag 6 -> x7=0x22, busy 1, tag 6.
REQ-030 Flush cycle: clearIn=1, commit x9=0x55, rename x10 -> x9=0x55, all busy 0, x10 not renamed.
REQ-031 Rename x0 and commit x0=0xFF -> x0 reads 0, busy 0; readyIn low holds every other state.
REQ-032 resetIn low with readyIn low and renames active -> all state zero on the next edge.
